wshb_arbiter_2m: RTL

WSHB_ARBITER_2M -- requirements
Module: wshb_arbiter_2m

---
 rtl/wshb_arbiter_2m.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/wshb_arbiter_2m.sv
`default_nettype none
// ============================================================================
// Module      : wshb_arbiter_2m
// Description : Two-master round-robin Wishbone arbiter with a slave watchdog
//               that forces an error on the owner when a termination is late.
// Revision    : 1.0 - initial release
// ============================================================================
module wshb_arbiter_2m #(
  parameter int DATA_BYTES = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 1023
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  // master 0
  input  logic                    m0_cyc,
  input  logic                    m0_stb,
  input  logic                    m0_we,
  input  logic [ADDR_WIDTH-1:0]   m0_adr,
  input  logic [8*DATA_BYTES-1:0] m0_dat_ms,
  input  logic [DATA_BYTES-1:0]   m0_sel,
  input  logic [2:0]              m0_cti,
  input  logic [1:0]              m0_bte,
  output logic                    m0_ack,
  output logic                    m0_err,
  output logic                    m0_rty,
  output logic [8*DATA_BYTES-1:0] m0_dat_sm,
  // master 1
  input  logic                    m1_cyc,
  input  logic                    m1_stb,
  input  logic                    m1_we,
  input  logic [ADDR_WIDTH-1:0]   m1_adr,
  input  logic [8*DATA_BYTES-1:0] m1_dat_ms,
  input  logic [DATA_BYTES-1:0]   m1_sel,
  input  logic [2:0]              m1_cti,
  input  logic [1:0]              m1_bte,
  output logic                    m1_ack,
  output logic                    m1_err,
  output logic                    m1_rty,
  output logic [8*DATA_BYTES-1:0] m1_dat_sm,
  // slave side
  output logic                    s_cyc,
  output logic                    s_stb,
  output logic                    s_we,
  output logic [ADDR_WIDTH-1:0]   s_adr,
  output logic [8*DATA_BYTES-1:0] s_dat_ms,
  output logic [DATA_BYTES-1:0]   s_sel,
  output logic [2:0]              s_cti,
  output logic [1:0]              s_bte,
  input  logic                    s_ack,
  input  logic                    s_err,
  input  logic                    s_rty,
  input  logic [8*DATA_BYTES-1:0] s_dat_sm,
  // status
  output logic [1:0]              grant,
  output logic [7:0]              timeout_cnt
);

  localparam int c_WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [c_WD_W-1:0] c_WD_MAX = c_WD_W'(TIMEOUT);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_GNT0 = 2'd1;
  localparam logic [1:0] c_GNT1 = 2'd2;

  logic [1:0]        r_state;
  logic              r_last;
  logic [c_WD_W-1:0] r_wd;
  logic [7:0]        r_timeout_cnt;

  logic [1:0]        w_state_nxt;
  logic              w_last_nxt;
  logic              w_own0;
  logic              w_own1;
  logic              w_cyc;
  logic              w_stb;
  logic              w_pending;
  logic              w_expire;

  assign w_own0 = (r_state == c_GNT0);
  assign w_own1 = (r_state == c_GNT1);

  // On a tie in IDLE the master that was not served last wins.
  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    case (r_state)
      c_IDLE: begin
        if (m0_cyc && (!m1_cyc || r_last)) begin
          w_state_nxt = c_GNT0;
        end else if (m1_cyc) begin
          w_state_nxt = c_GNT1;
        end
      end
      c_GNT0: begin
        if (!m0_cyc) begin
          w_state_nxt = c_IDLE;
          w_last_nxt  = 1'b0;
        end
      end
      c_GNT1: begin
        if (!m1_cyc) begin
          w_state_nxt = c_IDLE;
          w_last_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = c_IDLE;
    endcase
  end

  always_comb begin
    w_cyc    = 1'b0;
    w_stb    = 1'b0;
    s_we     = 1'b0;
    s_adr    = '0;
    s_dat_ms = '0;
    s_sel    = '0;
    s_cti    = '0;
    s_bte    = '0;
    if (w_own0) begin
      w_cyc    = m0_cyc;
      w_stb    = m0_stb;
      s_we     = m0_we;
      s_adr    = m0_adr;
      s_dat_ms = m0_dat_ms;
      s_sel    = m0_sel;
      s_cti    = m0_cti;
      s_bte    = m0_bte;
    end else if (w_own1) begin
      w_cyc    = m1_cyc;
      w_stb    = m1_stb;
      s_we     = m1_we;
      s_adr    = m1_adr;
      s_dat_ms = m1_dat_ms;
      s_sel    = m1_sel;
      s_cti    = m1_cti;
      s_bte    = m1_bte;
    end
  end

  // A slave termination in the expiry cycle suppresses the forced error.
  assign w_pending = w_cyc & w_stb & ~s_ack & ~s_err & ~s_rty;
  assign w_expire  = w_pending & (r_wd == c_WD_MAX);

  assign s_cyc = w_cyc;
  assign s_stb = w_stb & ~w_expire;

  assign m0_ack    = w_own0 & s_ack;
  assign m0_err    = w_own0 & (s_err | w_expire);
  assign m0_rty    = w_own0 & s_rty;
  assign m0_dat_sm = w_own0 ? s_dat_sm : '0;

  assign m1_ack    = w_own1 & s_ack;
  assign m1_err    = w_own1 & (s_err | w_expire);
  assign m1_rty    = w_own1 & s_rty;
  assign m1_dat_sm = w_own1 ? s_dat_sm : '0;

  assign grant       = {w_own1, w_own0};
  assign timeout_cnt = r_timeout_cnt;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state       <= c_IDLE;
      r_last        <= 1'b1;
      r_wd          <= '0;
      r_timeout_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
      if (w_pending && !w_expire) begin
        r_wd <= r_wd + c_WD_W'(1);
      end else begin
        r_wd <= '0;
      end
      if (w_expire && (r_timeout_cnt != 8'hFF)) begin
        r_timeout_cnt <= r_timeout_cnt + 8'd1;
      end
    end
  end

endmodule
`default_nettype wire
